// File: rtl/clint_pkg.sv
// clint_pkg: shared encodings for the core-local interrupt controller.
//   - int_state_t : combinational request class seen at the decode boundary
//   - csr_state_t : registered CSR-update sequencer state
//   - CSR addresses, trap/return instruction encodings, mstatus bit indices
package clint_pkg;

  typedef enum logic [1:0] {
    INT_IDLE,
    INT_SYNC,
    INT_ASYNC,
    INT_MRET
  } int_state_t;

  typedef enum logic [2:0] {
    CSR_IDLE,
    CSR_MEPC,
    CSR_MSTATUS,
    CSR_MCAUSE,
    CSR_MRET
  } csr_state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/clint.sv
// clint: core-local interrupt controller.
// Detects ecall/ebreak, mret and enabled external interrupts at decode,
// sequences the mepc/mstatus/mcause writes through the CSR write port and
// redirects the PC to mtvec (trap) or mepc (mret).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   int_flag_i          : level-sensitive external interrupt lines
//   inst_i, inst_addr_i : instruction in decode and its address
//   jump_flag_i/addr_i  : EX redirect this cycle (return PC for async traps)
//   div_started_i       : divide in flight, masks async interrupts
//   csr_mtvec_i/mepc_i/mstatus_i : current CSR values
//   hold_flag_o         : pipeline hold request (combinational)
//   we_o, waddr_o, data_o : registered CSR write port
//   int_assert_o, int_addr_o : registered one-cycle PC redirect
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] CAUSE_ASYNC  = 32'h8000_0004,
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK = 32'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        div_started_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [11:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  int_state_t  int_state;
  csr_state_t  csr_state;
  logic [31:0] cause_q;

  // Trap entry: save MIE into MPIE, then disable interrupts.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r               = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  // Request classification, priority SYNC > MRET > ASYNC.
  always_comb begin
    int_state = INT_IDLE;
    if (inst_i == INST_ECALL || inst_i == INST_EBREAK) begin
      int_state = INT_SYNC;
    end else if (inst_i == INST_MRET) begin
      int_state = INT_MRET;
    end else if (int_flag_i != 8'h00 && csr_mstatus_i[MSTATUS_MIE] && !div_started_i) begin
      int_state = INT_ASYNC;
    end
  end

  assign hold_flag_o = (int_state != INT_IDLE) || (csr_state != CSR_IDLE);

  // The output registers are loaded on the edge that enters a state, so each
  // write is visible during the cycle the sequencer sits in that state; the
  // redirect pulse is loaded on the edge that leaves the final state.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_state    <= CSR_IDLE;
      cause_q      <= '0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      we_o         <= 1'b0;
      waddr_o      <= '0;
      data_o       <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (csr_state)
        CSR_IDLE: begin
          case (int_state)
            INT_SYNC: begin
              cause_q   <= (inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
              csr_state <= CSR_MEPC;
              we_o      <= 1'b1;
              waddr_o   <= ADDR_MEPC;
              data_o    <= inst_addr_i;
            end
            INT_ASYNC: begin
              // An interrupt taken under a redirect returns to the jump target.
              cause_q   <= CAUSE_ASYNC;
              csr_state <= CSR_MEPC;
              we_o      <= 1'b1;
              waddr_o   <= ADDR_MEPC;
              data_o    <= jump_flag_i ? jump_addr_i : inst_addr_i;
            end
            INT_MRET: begin
              csr_state <= CSR_MRET;
              we_o      <= 1'b1;
              waddr_o   <= ADDR_MSTATUS;
              data_o    <= mret_mstatus(csr_mstatus_i);
            end
            default: csr_state <= CSR_IDLE;
          endcase
        end
        CSR_MEPC: begin
          csr_state <= CSR_MSTATUS;
          we_o      <= 1'b1;
          waddr_o   <= ADDR_MSTATUS;
          data_o    <= trap_mstatus(csr_mstatus_i);
        end
        CSR_MSTATUS: begin
          csr_state <= CSR_MCAUSE;
          we_o      <= 1'b1;
          waddr_o   <= ADDR_MCAUSE;
          data_o    <= cause_q;
        end
        CSR_MCAUSE: begin
          csr_state    <= CSR_IDLE;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mtvec_i;
        end
        CSR_MRET: begin
          csr_state    <= CSR_IDLE;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        default: csr_state <= CSR_IDLE;
      endcase
    end
  end

endmodule
